// File: rtl/immediate_expander.sv
// ARMv7 immediate expansion unit: decodes DP rotated immediates, load/store,
// halfword, branch and SWI offsets behind a valid/ready handshake with an iterative rotator.
module immediate_expander #(
  parameter int DATA_W   = 32,
  parameter int ROT_STEP = 2
) (
  input  logic              i_Clk,
  input  logic              i_Reset,
  input  logic              i_Valid,
  output logic              o_Ready,
  input  logic [23:0]       i_Immediate_24,
  input  logic [2:0]        i_Immediate_Src,
  input  logic              i_Carry,
  output logic              o_Valid,
  input  logic              i_Ready,
  output logic [DATA_W-1:0] o_Immediate,
  output logic              o_Carry,
  output logic              o_Illegal
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ROT  = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  localparam logic [2:0] MODE_DP  = 3'b000;
  localparam logic [2:0] MODE_LS  = 3'b001;
  localparam logic [2:0] MODE_BR  = 3'b010;
  localparam logic [2:0] MODE_HW  = 3'b011;
  localparam logic [2:0] MODE_SWI = 3'b100;
  localparam logic [5:0] STEP     = 6'(ROT_STEP);

  function automatic logic [31:0] ror32(input logic [31:0] x, input logic [4:0] amt);
    logic [63:0] both;
    both = {x, x} >> amt;
    return both[31:0];
  endfunction

  // Expansion for every request that completes without using the rotator.
  function automatic logic [DATA_W-1:0] expand(input logic [2:0] mode, input logic [23:0] imm);
    logic [DATA_W-1:0] res;
    case (mode)
      MODE_DP:  res = DATA_W'(imm[7:0]);
      MODE_LS:  res = DATA_W'(imm[11:0]);
      MODE_BR:  res = {{(DATA_W-26){imm[23]}}, imm, 2'b00};
      MODE_HW:  res = DATA_W'({imm[11:8], imm[3:0]});
      MODE_SWI: res = DATA_W'(imm);
      default:  res = '0;
    endcase
    return res;
  endfunction

  state_t            state_q, state_d;
  logic [31:0]       work_q, work_d;
  logic [4:0]        rem_q, rem_d;
  logic              cin_q, cin_d;
  logic              valid_q, valid_d;
  logic [DATA_W-1:0] imm_q, imm_d;
  logic              carry_q, carry_d;
  logic              illegal_q, illegal_d;

  logic              ready_s;
  logic              accept_s;
  logic              consume_s;
  logic [4:0]        req_rot_s;
  logic              req_rotates_s;
  logic [4:0]        step_s;
  logic [4:0]        rem_next_s;
  logic [31:0]       rotated_s;

  // Only i_Ready reaches o_Ready combinationally, and only while a result is held.
  always_comb begin
    case (state_q)
      ST_IDLE: ready_s = 1'b1;
      ST_HOLD: ready_s = i_Ready;
      default: ready_s = 1'b0;
    endcase
  end

  assign accept_s      = i_Valid & ready_s;
  assign consume_s     = valid_q & i_Ready;
  assign req_rot_s     = {i_Immediate_24[11:8], 1'b0};
  assign req_rotates_s = (i_Immediate_Src == MODE_DP) && (req_rot_s != 5'd0);

  // Rotate by at most one step per cycle, never overshooting the remaining amount.
  always_comb begin
    if ({1'b0, rem_q} > STEP) begin
      step_s = STEP[4:0];
    end else begin
      step_s = rem_q;
    end
    rem_next_s = rem_q - step_s;
    rotated_s  = ror32(work_q, step_s);
  end

  // Next-state: progress the current request, then let a new accept override it.
  always_comb begin
    state_d   = state_q;
    work_d    = work_q;
    rem_d     = rem_q;
    cin_d     = cin_q;
    valid_d   = valid_q;
    imm_d     = imm_q;
    carry_d   = carry_q;
    illegal_d = illegal_q;

    case (state_q)
      ST_IDLE: begin
        valid_d = 1'b0;
      end
      ST_ROT: begin
        work_d = rotated_s;
        rem_d  = rem_next_s;
        if (rem_next_s == 5'd0) begin
          state_d   = ST_HOLD;
          valid_d   = 1'b1;
          imm_d     = DATA_W'(rotated_s);
          carry_d   = rotated_s[31];
          illegal_d = 1'b0;
        end else begin
          state_d = ST_ROT;
        end
      end
      ST_HOLD: begin
        if (consume_s) begin
          state_d = ST_IDLE;
          valid_d = 1'b0;
        end else begin
          state_d = ST_HOLD;
        end
      end
      default: begin
        state_d = ST_IDLE;
        valid_d = 1'b0;
      end
    endcase

    if (accept_s) begin
      cin_d = i_Carry;
      if (req_rotates_s) begin
        state_d = ST_ROT;
        valid_d = 1'b0;
        work_d  = {24'd0, i_Immediate_24[7:0]};
        rem_d   = req_rot_s;
      end else begin
        state_d   = ST_HOLD;
        valid_d   = 1'b1;
        imm_d     = expand(i_Immediate_Src, i_Immediate_24);
        carry_d   = i_Carry;
        illegal_d = (i_Immediate_Src > MODE_SWI);
      end
    end else begin
      cin_d = cin_q;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      state_q   <= ST_IDLE;
      work_q    <= 32'd0;
      rem_q     <= 5'd0;
      cin_q     <= 1'b0;
      valid_q   <= 1'b0;
      imm_q     <= '0;
      carry_q   <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      work_q    <= work_d;
      rem_q     <= rem_d;
      cin_q     <= cin_d;
      valid_q   <= valid_d;
      imm_q     <= imm_d;
      carry_q   <= carry_d;
      illegal_q <= illegal_d;
    end
  end

  assign o_Ready     = ready_s;
  assign o_Valid     = valid_q;
  assign o_Immediate = imm_q;
  assign o_Carry     = carry_q;
  assign o_Illegal   = illegal_q;

endmodule

// File: tb/tb_immediate_expander.sv
// Directed bench for immediate_expander: one instance at ROT_STEP=2, one at ROT_STEP=8.
module tb_immediate_expander;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        sel8;
  logic [23:0] imm;
  logic [2:0]  src;
  logic        cin;
  logic        i_ready;

  logic        v2, r2, c2, il2;
  logic [31:0] o2;
  logic        v8, r8, c8, il8;
  logic [31:0] o8;

  logic        s_valid, s_ready, s_carry, s_ill;
  logic [31:0] s_imm;

  int n_cmp = 0;
  int n_bad = 0;

  immediate_expander #(.DATA_W(32), .ROT_STEP(2)) dut2 (
    .i_Clk(clk), .i_Reset(rst), .i_Valid(req_valid & ~sel8), .o_Ready(r2),
    .i_Immediate_24(imm), .i_Immediate_Src(src), .i_Carry(cin),
    .o_Valid(v2), .i_Ready(i_ready), .o_Immediate(o2), .o_Carry(c2), .o_Illegal(il2)
  );

  immediate_expander #(.DATA_W(32), .ROT_STEP(8)) dut8 (
    .i_Clk(clk), .i_Reset(rst), .i_Valid(req_valid & sel8), .o_Ready(r8),
    .i_Immediate_24(imm), .i_Immediate_Src(src), .i_Carry(cin),
    .o_Valid(v8), .i_Ready(i_ready), .o_Immediate(o8), .o_Carry(c8), .o_Illegal(il8)
  );

  assign s_valid = sel8 ? v8  : v2;
  assign s_ready = sel8 ? r8  : r2;
  assign s_carry = sel8 ? c8  : c2;
  assign s_ill   = sel8 ? il8 : il2;
  assign s_imm   = sel8 ? o8  : o2;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic run_req(input string tag, input bit use8, input logic [2:0] mode,
                         input logic [23:0] value, input logic c,
                         input int exp_lat, input logic [31:0] exp_val,
                         input logic exp_c, input logic exp_ill);
    int lat;
    sel8 = use8; src = mode; imm = value; cin = c; req_valid = 1'b1; i_ready = 1'b0;
    tick();
    req_valid = 1'b0; imm = 24'h5A5A5A; src = 3'b001; cin = ~c;
    lat = 1;
    while (!s_valid && lat < 40) begin
      tick();
      lat++;
    end
    chk({tag, "-valid"}, 32'(s_valid), 32'd1);
    chk({tag, "-lat"}, 32'(lat), 32'(exp_lat));
    chk({tag, "-val"}, s_imm, exp_val);
    chk({tag, "-carry"}, 32'(s_carry), 32'(exp_c));
    chk({tag, "-ill"}, 32'(s_ill), 32'(exp_ill));
    chk({tag, "-ready"}, 32'(s_ready), 32'd0);
    i_ready = 1'b1;
    tick();
    i_ready = 1'b0;
    chk({tag, "-drop"}, 32'(s_valid), 32'd0);
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; sel8 = 1'b0; imm = 24'd0; src = 3'd0;
    cin = 1'b0; i_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    chk("rst-valid", 32'(v2), 32'd0);
    chk("rst-ready", 32'(r2), 32'd1);
    chk("rst-imm", o2, 32'd0);
    chk("rst-carry", 32'(c2), 32'd0);
    chk("rst-ill", 32'(il2), 32'd0);

    // DP rotate by 8 at step 2: four ROT cycles, then held under backpressure.
    src = 3'b000; imm = 24'h0004FF; cin = 1'b0; req_valid = 1'b1;
    tick();
    req_valid = 1'b0; imm = 24'hFFFFFF;
    chk("rot-ready", 32'(r2), 32'd0);
    chk("rot-valid0", 32'(v2), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rot-busy", 32'(v2 | r2), 32'd0);
    end
    tick();
    chk("rot-valid", 32'(v2), 32'd1);
    chk("rot-val", o2, 32'hFF000000);
    chk("rot-carry", 32'(c2), 32'd1);
    chk("rot-ill", 32'(il2), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("bp-valid", 32'(v2), 32'd1);
      chk("bp-val", o2, 32'hFF000000);
      chk("bp-carry", 32'(c2), 32'd1);
      chk("bp-ready", 32'(r2), 32'd0);
    end

    // Consume and accept on the same edge.
    i_ready = 1'b1; req_valid = 1'b1; src = 3'b001; imm = 24'h000FFF; cin = 1'b1;
    #1;
    chk("b2b-ready", 32'(r2), 32'd1);
    tick();
    req_valid = 1'b0; i_ready = 1'b0; imm = 24'h000000;
    chk("b2b-valid", 32'(v2), 32'd1);
    chk("b2b-val", o2, 32'h00000FFF);
    chk("b2b-carry", 32'(c2), 32'd1);
    i_ready = 1'b1;
    tick();
    i_ready = 1'b0;
    chk("b2b-drop", 32'(v2), 32'd0);
    chk("b2b-idle", 32'(r2), 32'd1);

    run_req("dp-rot0", 1'b0, 3'b000, 24'h0000AB, 1'b1, 1,  32'h000000AB, 1'b1, 1'b0);
    run_req("dp-s8",   1'b1, 3'b000, 24'h000F03, 1'b1, 5,  32'h0000000C, 1'b0, 1'b0);
    run_req("dp-r30",  1'b0, 3'b000, 24'h000F03, 1'b1, 16, 32'h0000000C, 1'b0, 1'b0);
    run_req("branch",  1'b0, 3'b010, 24'hFFFFFE, 1'b0, 1,  32'hFFFFFFF8, 1'b0, 1'b0);
    run_req("half",    1'b0, 3'b011, 24'h000A05, 1'b1, 1,  32'h000000A5, 1'b1, 1'b0);
    run_req("ill7",    1'b0, 3'b111, 24'hABCDEF, 1'b1, 1,  32'h00000000, 1'b1, 1'b1);
    run_req("ill5",    1'b0, 3'b101, 24'h123456, 1'b0, 1,  32'h00000000, 1'b0, 1'b1);
    run_req("swi",     1'b0, 3'b100, 24'h123456, 1'b0, 1,  32'h00123456, 1'b0, 1'b0);

    // Reset during the third ROT cycle discards the request.
    sel8 = 1'b0; src = 3'b000; imm = 24'h000F01; cin = 1'b1; req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mrst-valid", 32'(v2), 32'd0);
    chk("mrst-ready", 32'(r2), 32'd1);
    chk("mrst-imm", o2, 32'd0);
    chk("mrst-carry", 32'(c2), 32'd0);
    chk("mrst-ill", 32'(il2), 32'd0);
    tick();
    chk("mrst-quiet", 32'(v2), 32'd0);
    run_req("fresh", 1'b0, 3'b000, 24'h000F01, 1'b1, 16, 32'h00000004, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
